// File: rtl/io_bus_master_if.sv
// Bundle of the client request/response handshake and the IO slave bus.
// The master modport is the io_bus_master view; the slave modport is the
// view of whatever sits around it (client plus IO slave).
interface io_bus_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [15:0] req_dat_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        io_stb_o;
    logic        io_we_o;
    logic [15:0] io_addr_o;
    logic [15:0] io_dat_o;
    logic        io_ack_i;
    logic [15:0] io_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_dat_i, io_ack_i, io_dat_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               io_stb_o, io_we_o, io_addr_o, io_dat_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_dat_i, io_ack_i, io_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               io_stb_o, io_we_o, io_addr_o, io_dat_o
    );
endinterface

// File: rtl/io_bus_master.sv
// Single-outstanding IO bus master: takes one client request, runs it on the
// IO strobe bus until the slave acknowledges or the wait budget runs out,
// then returns a one-cycle response strobe with data and a timeout flag.
module io_bus_master #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic            clk_i,
    input  logic            rst_i,
    io_bus_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen on the last allowed no-ack cycle; the strobe is then
    // high for exactly TIMEOUT cycles before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] dat_q;
    logic [15:0] rsp_dat_q;
    logic        rsp_err_q;
    logic        capture_req;
    logic        finish_ok;
    logic        finish_err;

    // State register; reset is asynchronous so the strobe drops immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over the timeout on the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_req = 1'b0;
        finish_ok   = 1'b0;
        finish_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    capture_req = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                if (bus.io_ack_i) begin
                    finish_ok = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == TO_LAST) begin
                    finish_err = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response registers (held between responses).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            dat_q     <= 16'h0000;
            rsp_dat_q <= 16'h0000;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (capture_req) begin
                we_q   <= bus.req_we_i;
                addr_q <= bus.req_addr_i;
                dat_q  <= bus.req_dat_i;
            end
            if (finish_ok) begin
                rsp_dat_q <= we_q ? 16'h0000 : bus.io_dat_i;
                rsp_err_q <= 1'b0;
            end else if (finish_err) begin
                rsp_dat_q <= 16'h0000;
                rsp_err_q <= 1'b1;
            end
        end
    end

    // Bus outputs are decoded from state so they are zero outside BUS.
    always_comb begin
        bus.req_ready_o = (state_q == IDLE);
        bus.rsp_valid_o = (state_q == RESP);
        bus.rsp_dat_o   = rsp_dat_q;
        bus.rsp_err_o   = rsp_err_q;
        bus.io_stb_o    = 1'b0;
        bus.io_we_o     = 1'b0;
        bus.io_addr_o   = 16'h0000;
        bus.io_dat_o    = 16'h0000;
        if (state_q == BUS) begin
            bus.io_stb_o  = 1'b1;
            bus.io_we_o   = we_q;
            bus.io_addr_o = addr_q;
            bus.io_dat_o  = dat_q;
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: expected responses are queued when a
// request is issued and compared when the response strobe appears.
module tb_io_bus_master;

    localparam int TIMEOUT = 63;

    typedef struct packed {
        logic [15:0] dat;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst;
    logic ack_stb_en;
    logic ack_force;
    logic slave_mirror;
    logic [15:0] rd_data;
    int vectors;
    int miscompares;
    rsp_t expq[$];

    io_bus_master_if bus ();

    io_bus_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // IO slave model: ack either forced or tied to the strobe on a chosen cycle.
    assign bus.io_ack_i = ack_force | (ack_stb_en & bus.io_stb_o);
    assign bus.io_dat_i = slave_mirror ? (bus.io_addr_o ^ 16'h5A5A) : rd_data;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one request from IDLE and follow it to its response.
    // ackDelay < 0 means the slave never answers.
    task automatic applyStimulus(input string tag, input logic we, input logic [15:0] addr,
                                 input logic [15:0] dat, input int ackDelay,
                                 input logic [15:0] rdVal);
        rsp_t exp;
        rsp_t got;
        int   expStb;
        int   stbCount;
        int   rspCycle;
        int   badBus;
        logic firstStb;
        if (ackDelay < 0 || ackDelay >= TIMEOUT) begin
            exp.dat = 16'h0000;
            exp.err = 1'b1;
            expStb  = TIMEOUT;
        end else begin
            exp.dat = we ? 16'h0000 : rdVal;
            exp.err = 1'b0;
            expStb  = ackDelay + 1;
        end
        rd_data = rdVal;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_dat_i   = dat;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
        expq.push_back(exp);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 16'hFFFF;
        bus.req_dat_i   = 16'hFFFF;
        stbCount = 0;
        rspCycle = -1;
        badBus   = 0;
        firstStb = 1'b0;
        for (int c = 0; c < 400 && rspCycle < 0; c++) begin
            ack_stb_en = (ackDelay >= 0) && (stbCount == ackDelay);
            @(negedge clk);
            if (c == 0) firstStb = bus.io_stb_o;
            if (bus.io_stb_o) begin
                stbCount++;
                if ({bus.io_we_o, bus.io_addr_o, bus.io_dat_o} !== {we, addr, dat}) badBus++;
            end else if ({bus.io_we_o, bus.io_addr_o, bus.io_dat_o} !== 33'd0) begin
                badBus++;
            end
            if (bus.rsp_valid_o) begin
                rspCycle = c;
                if (expq.size() == 0) begin
                    checkOutput({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
                end else begin
                    got.dat = bus.rsp_dat_o;
                    got.err = bus.rsp_err_o;
                    exp = expq.pop_front();
                    checkOutput({tag, "_rsp_dat"}, 32'(got.dat), 32'(exp.dat));
                    checkOutput({tag, "_rsp_err"}, 32'(got.err), 32'(exp.err));
                end
            end
            @(posedge clk);
            #1;
        end
        ack_stb_en = 1'b0;
        checkOutput({tag, "_stb_latency"}, 32'(firstStb), 32'd1);
        checkOutput({tag, "_stb_cycles"}, 32'(stbCount), 32'(expStb));
        checkOutput({tag, "_rsp_cycle"}, 32'(rspCycle), 32'(expStb));
        checkOutput({tag, "_bus_stable"}, 32'(badBus), 32'd0);
        checkOutput({tag, "_idle_after"}, {30'd0, bus.req_ready_o, bus.rsp_valid_o}, 32'b10);
        checkOutput({tag, "_rsp_hold"}, {15'd0, bus.rsp_err_o, bus.rsp_dat_o},
                    {15'd0, exp.err, exp.dat});
    endtask

    initial begin
        int   burstIdx;
        int   lastAcc;
        int   spurious;
        logic accepted;
        rsp_t exp;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        ack_stb_en   = 1'b0;
        ack_force    = 1'b0;
        slave_mirror = 1'b0;
        rd_data      = 16'h0000;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 16'h0000;
        bus.req_dat_i   = 16'h0000;

        // Reset values
        @(negedge clk);
        checkOutput("reset_ctrl", {27'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                    bus.io_stb_o, bus.io_we_o}, 32'b10000);
        checkOutput("reset_rsp_dat", 32'(bus.rsp_dat_o), 32'd0);
        checkOutput("reset_io_addr_dat", {bus.io_addr_o, bus.io_dat_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] read with zero-wait ack");
        applyStimulus("rd0", 1'b0, 16'h0004, 16'h0000, 0, 16'h1234);
        $display("[TB] write with three wait cycles");
        applyStimulus("wr3", 1'b1, 16'h0002, 16'h0100, 3, 16'hDEAD);
        $display("[TB] read timeout");
        applyStimulus("rd_to", 1'b0, 16'h0010, 16'h0000, -1, 16'h7777);
        $display("[TB] read acked on the timeout cycle");
        applyStimulus("rd_ack63", 1'b0, 16'h0020, 16'h0000, TIMEOUT - 1, 16'hBEEF);

        // Back-to-back reads with request held and ack stuck high everywhere
        $display("[TB] back-to-back requests");
        slave_mirror    = 1'b1;
        ack_force       = 1'b1;
        burstIdx        = 0;
        lastAcc         = -1;
        spurious        = 0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 16'h0100;
        bus.req_dat_i   = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            accepted = 1'b0;
            if (bus.rsp_valid_o) begin
                if (expq.size() == 0) begin
                    spurious++;
                end else begin
                    exp = expq.pop_front();
                    checkOutput("b2b_rsp", {15'd0, bus.rsp_err_o, bus.rsp_dat_o},
                                {15'd0, exp.err, exp.dat});
                end
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                if (lastAcc >= 0) checkOutput("b2b_spacing", 32'(c - lastAcc), 32'd3);
                exp.dat = bus.req_addr_i ^ 16'h5A5A;
                exp.err = 1'b0;
                expq.push_back(exp);
                lastAcc  = c;
                accepted = 1'b1;
                burstIdx++;
            end
            @(posedge clk);
            #1;
            if (accepted) begin
                if (burstIdx == 4) bus.req_valid_i = 1'b0;
                else bus.req_addr_i = 16'h0100 + 16'(burstIdx * 2);
            end
        end
        ack_force    = 1'b0;
        slave_mirror = 1'b0;
        checkOutput("b2b_accepts", 32'(burstIdx), 32'd4);
        checkOutput("b2b_drained", 32'(expq.size()), 32'd0);
        checkOutput("b2b_spurious_rsp", 32'(spurious), 32'd0);

        // Reset in the middle of a bus cycle
        $display("[TB] reset during bus phase");
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 16'h0040;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midbus_stb_before", 32'(bus.io_stb_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midbus_stb_async", 32'(bus.io_stb_o), 32'd0);
        checkOutput("midbus_ready_async", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.io_stb_o) spurious++;
        end
        checkOutput("midbus_no_rsp", 32'(spurious), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus("rd_after_rst", 1'b0, 16'h0008, 16'h0000, 1, 16'hC0DE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 63, max bus cycles waited for io_ack_i before abort; range 1..255.
REQ-002 clk_i  input  1  clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  client request present.
REQ-005 req_ready_o  output  1  block can accept a request.
REQ-006 req_we_i  input  1  1 = write, 0 = read.
REQ-007 req_addr_i  input  16  target IO register address.
REQ-008 req_dat_i  input  16  write data.
REQ-009 rsp_valid_o  output  1  one-cycle response strobe.
REQ-010 rsp_dat_o  output  16  read data; 0 for writes and errors.
REQ-011 rsp_err_o  output  1  timeout flag, valid with rsp_valid_o.
REQ-012 io_stb_o  output  1  bus strobe to IO slave.
REQ-013 io_we_o  output  1  bus write enable.
REQ-014 io_addr_o  output  16  bus address.
REQ-015 io_dat_o  output  16  bus write data.
REQ-016 io_ack_i  input  1  slave acknowledge; may be combinational from io_stb_o.
REQ-017 io_dat_i  input  16  slave read data, valid when io_ack_i=1.

Function
REQ-018 FSM states IDLE, BUS, RESP; exactly one transaction outstanding at a time.
REQ-019 req_ready_o SHALL be 1 only in IDLE.
REQ-020 IDLE: on req_valid_i=1, latch req_we_i/req_addr_i/req_dat_i, clear wait counter, go BUS.
REQ-021 BUS: io_stb_o=1, io_we_o/io_addr_o/io_dat_o driven from latched values, held stable every BUS cycle.
REQ-022 io_stb_o, io_we_o SHALL be 0 and io_addr_o, io_dat_o SHALL be 0 outside BUS.
REQ-023 BUS with io_ack_i=1: read -> register io_dat_i into rsp_dat_o; write -> rsp_dat_o=0; rsp_err_o=0; go RESP.
REQ-024 BUS with io_ack_i=0: increment 8-bit wait counter; when counter equals TIMEOUT-1 on that cycle, go RESP with rsp_err_o=1, rsp_dat_o=0.
REQ-025 Ack and timeout in same cycle: ack wins, rsp_err_o=0.
REQ-026 Latency: request accepted cycle N, io_stb_o=1 at N+1; zero-wait ack at N+1 -> rsp_valid_o=1 at N+2; next acceptance earliest N+3.
REQ-027 Timeout: io_stb_o high exactly TIMEOUT cycles, rsp_valid_o the cycle after the last.
REQ-028 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_dat_o/rsp_err_o hold until next RESP.
REQ-029 io_ack_i outside BUS SHALL be ignored with no state change.
REQ-030 req_valid_i outside IDLE SHALL be ignored; client holds request until req_ready_o=1.
REQ-031 Counter SHALL not wrap; it is cleared on entry to BUS.

Reset
REQ-032 rst_i=1 forces IDLE immediately, regardless of clock.
REQ-033 Reset values: req_ready_o=1 (after IDLE entry), rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, io_stb_o=0, io_we_o=0, io_addr_o=0, io_dat_o=0, counter=0.
REQ-034 Reset during BUS SHALL drop io_stb_o asynchronously and produce no response.

Verification
REQ-035 Read, slave acks same cycle (ack=stb), addr 0x0004, io_dat_i=0x1234 -> one stb cycle, io_we_o=0, rsp_valid_o one cycle later, rsp_dat_o=0x1234, rsp_err_o=0.
REQ-036 Write addr 0x0002, data 0x0100, ack after 3 wait cycles -> stb high 4 cycles with stable addr/data, rsp_dat_o=0, rsp_err_o=0.
REQ-037 Read, no ack, TIMEOUT=63 -> stb high exactly 63 cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
REQ-038 Ack on cycle 63 (timeout cycle) -> normal completion, rsp_err_o=0, data captured.
REQ-039 Back-to-back requests with req_valid_i held high -> accepts every 3 cycles, spurious io_ack_i in IDLE/RESP ignored.
REQ-040 Assert rst_i mid-BUS -> io_stb_o=0 same cycle, no rsp_valid_o, next request after reset completes normally.
